flag_tracker: RTL and testbench
===============================

Name: flag_tracker

Overview:
- Registered, parametrised successor to the combinational zero/sign flag generators.
- Maintains per-register zero and sign flags for an NUM_REGS x WIDTH register file.
- Updates flags incrementally from the writeback port, with one cycle of latency.
- A resync FSM walks the register file through a read port and rebuilds every flag, for use after bulk loads or a debug write that bypasses writeback.

Parameters:
- NUM_REGS, 16, number of tracked registers; must be at least 2.
- WIDTH, 16, register width in bits; sign bit is WIDTH-1.
- AW, $clog2(NUM_REGS), address width; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback register index
- wr_data  in  WIDTH  writeback value
- sync_req  in  1  one-cycle pulse that starts a resync
- rd_en  out  1  register-file read strobe during resync
- rd_addr  out  AW  register-file read index
- rd_data  in  WIDTH  read data, valid the cycle after rd_en
- busy  out  1  high while a resync is in progress
- sync_done  out  1  one-cycle pulse when a resync completes
- zeroflag  out  NUM_REGS  bit i is 1 iff register i == 0
- signflag  out  NUM_REGS  bit i equals bit WIDTH-1 of register i

Behaviour:
- Reset (async, rst_n low):
  - zeroflag = all ones; signflag = 0.
  - rd_en = 0, rd_addr = 0, busy = 0, sync_done = 0.
  - FSM = IDLE; scan index = 0.
- Writeback path:
  - If wr_en is high at edge k, the flags for wr_addr reflect wr_data after edge k.
  - Other flag bits hold.
  - wr_addr >= NUM_REGS is ignored.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - sync_req moves to SCAN with idx = 0.
  - busy rises on the next cycle.
- SCAN:
  - Cycle j (0..NUM_REGS-1): rd_en = 1, rd_addr = j.
  - Cycle j+1: rd_data is captured into the flags of register j.
  - After the last issue there is one drain cycle with rd_en = 0.
  - The FSM then moves to DONE.
  - SCAN lasts NUM_REGS+1 cycles in total.
- DONE:
  - sync_done = 1 for one cycle; busy = 1.
  - Next state is IDLE, where busy = 0.
- sync_req while busy is ignored: it is neither queued nor restarted.
- Write/scan collision:
  - Applies when wr_en targets register r in the cycle r's read is issued or in its capture cycle.
  - The writeback value wins.
  - The scan capture for r is discarded, tracked by an in-flight dirty bit cleared at each capture.
- Writes to registers not currently in flight update normally during SCAN.
- Reset mid-scan aborts immediately to the reset values above, with no sync_done.
- Flags are pure register outputs; no combinational path from any input to zeroflag or signflag.

Optional Feature:
- Macro: FLAG_TRACKER_PARITY_EN.
- When defined:
  - Adds output port parityflag, width NUM_REGS, where bit i is the XOR reduction of register i.
  - Reset value is 0.
  - Updated on exactly the same writeback, scan and collision rules as the other flags.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package flag_pkg holds:
  - the FSM state enum (IDLE, SCAN, DONE);
  - the flag-bundle struct {zero, sign[, parity]};
  - reset-value constants.
- Sub-module flag_compute: combinational, WIDTH-parametrised, takes one word and returns its flag bundle.
- flag_compute is instantiated twice, once for the writeback path and once for the scan path.

Test Plan:
- Reset only -> zeroflag = 16'hFFFF, signflag = 16'h0000, busy = 0, rd_en = 0.
- Write r0 = 16'h000C, then r1 = 16'h8000 on consecutive cycles:
  - after the first edge, zeroflag = 16'hFFFE;
  - after the second edge, zeroflag = 16'hFFFC and signflag = 16'h0002.
- Model register file holding ri = 16'h8000 for odd i and 0 for even i; pulse sync_req:
  - rd_addr sequences 0..15;
  - busy high for 18 cycles and sync_done pulses exactly once;
  - finally zeroflag = 16'h5555 and signflag = 16'hAAAA.
- During a scan, write r5 = 16'h0001 in the cycle rd_addr = 5, while the model returns 0 for r5:
  - after DONE, zeroflag[5] = 0;
  - second sync_req asserted mid-scan produces no extra sync_done.
- Deassert rst_n in the middle of a scan:
  - flags return to 16'hFFFF / 16'h0000 asynchronously;
  - no sync_done pulse;
  - a fresh sync_req after release completes normally.
- FLAG_TRACKER_PARITY_EN defined, write r3 = 16'h0007 -> parityflag = 16'h0008.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared types for the flag tracker: resync FSM states, the per-word flag bundle, reset values.
// FLAG_TRACKER_PARITY_EN adds a parity bit to the bundle.
package flag_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic sign;
`ifdef FLAG_TRACKER_PARITY_EN
        logic parity;
`endif
    } flags_t;

    // A reset register file is treated as all-zero.
    localparam logic ZERO_RST   = 1'b1;
    localparam logic SIGN_RST   = 1'b0;
    localparam logic PARITY_RST = 1'b0;

endpackage

// File: rtl/flag_compute.sv
// Combinational flag bundle for one register word.
// FLAG_TRACKER_PARITY_EN also produces the XOR reduction.
module flag_compute
    import flag_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] word,
    output flags_t           flags
);

    always_comb begin
        flags      = '0;
        flags.zero = (word == '0);
        flags.sign = word[WIDTH-1];
`ifdef FLAG_TRACKER_PARITY_EN
        flags.parity = ^word;
`endif
    end

endmodule

// File: rtl/flag_tracker.sv
// Registered zero/sign flags for a NUM_REGS x WIDTH register file, updated from writeback and
// rebuilt by a resync scan. FLAG_TRACKER_PARITY_EN adds the parityflag output.
module flag_tracker
    import flag_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int WIDTH    = 16,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                sync_req,
    output logic                rd_en,
    output logic [AW-1:0]       rd_addr,
    input  logic [WIDTH-1:0]    rd_data,
    output logic                busy,
    output logic                sync_done,
    output logic [NUM_REGS-1:0] zeroflag,
    output logic [NUM_REGS-1:0] signflag
`ifdef FLAG_TRACKER_PARITY_EN
    ,
    output logic [NUM_REGS-1:0] parityflag
`endif
);

    state_t        state;
    logic [1:0]    vld_pipe;   // [0] read issued this cycle, [1] read data valid this cycle
    logic [AW-1:0] cap_addr;
    logic          dirty;
    logic          wr_ok;
    logic          cap_keep;
    flags_t        wb_f;
    flags_t        scan_f;

    assign rd_en = vld_pipe[0];

    assign wr_ok = wr_en && ({1'b0, wr_addr} < (AW+1)'(NUM_REGS));

    // A writeback to the register in flight (issue or capture cycle) beats the stale scan data.
    assign cap_keep = vld_pipe[1] && !dirty && !(wr_ok && (wr_addr == cap_addr));

    flag_compute #(.WIDTH(WIDTH)) u_wb_flags (
        .word  (wr_data),
        .flags (wb_f)
    );

    flag_compute #(.WIDTH(WIDTH)) u_scan_flags (
        .word  (rd_data),
        .flags (scan_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vld_pipe  <= '0;
            rd_addr   <= '0;
            cap_addr  <= '0;
            dirty     <= 1'b0;
            busy      <= 1'b0;
            sync_done <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            cap_addr    <= rd_addr;
            dirty       <= vld_pipe[0] && wr_ok && (wr_addr == rd_addr);
            sync_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_req) begin
                        state       <= SCAN;
                        busy        <= 1'b1;
                        vld_pipe[0] <= 1'b1;
                        rd_addr     <= '0;
                    end
                end
                SCAN: begin
                    if (vld_pipe[0]) begin
                        if (rd_addr == AW'(NUM_REGS - 1))
                            vld_pipe[0] <= 1'b0;
                        else
                            rd_addr <= rd_addr + 1'b1;
                    end else begin
                        // drain cycle: last capture lands on this edge
                        state     <= DONE;
                        sync_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zeroflag <= {NUM_REGS{ZERO_RST}};
            signflag <= {NUM_REGS{SIGN_RST}};
`ifdef FLAG_TRACKER_PARITY_EN
            parityflag <= {NUM_REGS{PARITY_RST}};
`endif
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && (wr_addr == AW'(i))) begin
                    zeroflag[i] <= wb_f.zero;
                    signflag[i] <= wb_f.sign;
`ifdef FLAG_TRACKER_PARITY_EN
                    parityflag[i] <= wb_f.parity;
`endif
                end else if (cap_keep && (cap_addr == AW'(i))) begin
                    zeroflag[i] <= scan_f.zero;
                    signflag[i] <= scan_f.sign;
`ifdef FLAG_TRACKER_PARITY_EN
                    parityflag[i] <= scan_f.parity;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_flag_tracker.sv
// Self-checking bench for flag_tracker: edge-indexed reference model plus directed and random stimulus.
module tb_flag_tracker;

    localparam int N  = 16;
    localparam int W  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          sync_req = 1'b0;
    logic [W-1:0]  rd_data = '0;
    logic          rd_en, busy, sync_done;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  zeroflag, signflag;
`ifdef FLAG_TRACKER_PARITY_EN
    logic [N-1:0]  parityflag;
`endif

    flag_tracker #(.NUM_REGS(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sync_req  (sync_req),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .sync_done (sync_done),
        .zeroflag  (zeroflag),
        .signflag  (signflag)
`ifdef FLAG_TRACKER_PARITY_EN
        ,
        .parityflag(parityflag)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_total = 0;
    int busy_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Register file seen through the read port: one cycle read latency.
    logic [W-1:0] mem [N];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    always @(negedge clk) begin
        if (sync_done) done_total++;
        if (busy) busy_total++;
    end

    // Reference model: edges are numbered from reset release; a scan accepted at edge e reads
    // register j during the cycle after edge e+j and applies it at edge e+j+2.
    logic [N-1:0] m_z, m_s, m_p;
    logic [W-1:0] snap [N];
    int  wedge [N];
    int  cyc, scan_e, j;
    bit  scanning, was_busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_z = '1; m_s = '0; m_p = '0;
            scanning = 0; cyc = 0; scan_e = 0;
            for (int i = 0; i < N; i++) wedge[i] = -10;
        end else begin
            cyc++;
            if (scanning) begin
                j = cyc - scan_e - 2;
                if (j >= 0 && j < N && wedge[j] != cyc - 1 && !(wr_en && int'(wr_addr) == j)) begin
                    m_z[j] = (snap[j] == 0);
                    m_s[j] = snap[j][W-1];
                    m_p[j] = ^snap[j];
                end
                j = cyc - scan_e - 1;
                if (j >= 0 && j < N) snap[j] = mem[j];
            end
            if (wr_en) begin
                m_z[wr_addr] = (wr_data == 0);
                m_s[wr_addr] = wr_data[W-1];
                m_p[wr_addr] = ^wr_data;
                wedge[wr_addr] = cyc;
            end
            was_busy = scanning;
            if (scanning && cyc == scan_e + N + 2) scanning = 0;
            if (!was_busy && sync_req) begin
                scanning = 1;
                scan_e = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("zeroflag", zeroflag, m_z);
            chk("signflag", signflag, m_s);
`ifdef FLAG_TRACKER_PARITY_EN
            chk("parityflag", parityflag, m_p);
`endif
            chk("busy", busy, scanning);
            chk("sync_done", sync_done, scanning && cyc == scan_e + N + 1);
            chk("rd_en", rd_en, scanning && (cyc - scan_e) < N);
            if (scanning && (cyc - scan_e) < N) chk("rd_addr", rd_addr, cyc - scan_e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_sync();
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
    endtask

    int d0, b0, nq;
    int addrs [$];
    bit did;

    initial begin
        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst zeroflag", zeroflag, 16'hFFFF);
        chk("rst signflag", signflag, 16'h0000);
        chk("rst busy", busy, 1'b0);
        chk("rst rd_en", rd_en, 1'b0);
        chk("rst sync_done", sync_done, 1'b0);

        tick();
        wr(3, 16'h0007);
`ifdef FLAG_TRACKER_PARITY_EN
        chk("parity r3", parityflag, 16'h0008);
`endif
        chk("zero r3", zeroflag, 16'hFFF7);
        wr(3, 16'h0000);

        wr_en = 1'b1; wr_addr = 0; wr_data = 16'h000C;
        tick();
        chk("wb1 zeroflag", zeroflag, 16'hFFFE);
        wr_addr = 1; wr_data = 16'h8000;
        tick();
        wr_en = 1'b0;
        chk("wb2 zeroflag", zeroflag, 16'hFFFC);
        chk("wb2 signflag", signflag, 16'h0002);

        // full resync over an alternating register file
        for (int i = 0; i < N; i++) mem[i] = (i % 2) ? 16'h8000 : 16'h0000;
        d0 = done_total; b0 = busy_total;
        pulse_sync();
        for (int k = 0; k < 30; k++) begin
            if (rd_en) addrs.push_back(int'(rd_addr));
            tick();
        end
        chk("scan busy cycles", busy_total - b0, 18);
        chk("scan done pulses", done_total - d0, 1);
        nq = addrs.size();
        chk("scan read count", nq, N);
        for (int i = 0; i < nq; i++) chk("scan rd_addr seq", addrs[i], i);
        chk("scan zeroflag", zeroflag, 16'h5555);
        chk("scan signflag", signflag, 16'hAAAA);

        // writeback collides with the read of r5; a second sync_req mid-scan is ignored
        mem[5] = 16'h0000;
        d0 = done_total;
        did = 0;
        pulse_sync();
        for (int k = 0; k < 30; k++) begin
            if (!did && rd_en && rd_addr == 5) begin
                did = 1;
                wr(5, 16'h0001);
                pulse_sync();
            end else begin
                tick();
            end
        end
        chk("collision write issued", did, 1'b1);
        chk("collision busy idle", busy, 1'b0);
        chk("collision zeroflag[5]", zeroflag[5], 1'b0);
        chk("collision done pulses", done_total - d0, 1);

        // reset in the middle of a scan
        pulse_sync();
        repeat (6) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("midrst zeroflag", zeroflag, 16'hFFFF);
        chk("midrst signflag", signflag, 16'h0000);
        chk("midrst busy", busy, 1'b0);
        chk("midrst rd_en", rd_en, 1'b0);
        d0 = done_total;
        repeat (3) tick();
        chk("midrst no done", done_total - d0, 0);
        rst_n = 1'b1;
        tick();
        pulse_sync();
        repeat (25) tick();
        chk("post-rst done", done_total - d0, 1);
        chk("post-rst zeroflag", zeroflag, 16'h5575);
        chk("post-rst signflag", signflag, 16'hAA8A);

        // random writes, sync requests and register-file changes, checked by the model
        for (int k = 0; k < 600; k++) begin
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = AW'($urandom_range(0, N - 1));
            wr_data  = ($urandom_range(0, 3) == 0) ? 16'h0000 : W'($urandom);
            sync_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                mem[$urandom_range(0, N - 1)] = ($urandom_range(0, 2) == 0) ? 16'h0000 : W'($urandom);
            tick();
        end
        wr_en = 1'b0;
        sync_req = 1'b0;
        repeat (25) tick();
        chk("final idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
